// File: rtl/store_controller_if.sv
// Store-buffer pull channel and data-memory write bus seen by store_controller.
// The slave modport is the controller's view; master is the store buffer plus bus side.
interface store_controller_if;
    logic        st_request_i;
    logic [31:0] st_address_i;
    logic [31:0] st_data_i;
    logic [1:0]  st_width_i;
    logic        st_done_o;
    logic        st_error_o;

    logic        bus_write_o;
    logic [31:0] bus_address_o;
    logic [31:0] bus_data_o;
    logic [3:0]  bus_byte_en_o;
    logic        bus_ready_i;
    logic        bus_done_i;
    logic        bus_error_i;

    modport slave (
        input  st_request_i, st_address_i, st_data_i, st_width_i,
        output st_done_o, st_error_o,
        output bus_write_o, bus_address_o, bus_data_o, bus_byte_en_o,
        input  bus_ready_i, bus_done_i, bus_error_i
    );

    modport master (
        output st_request_i, st_address_i, st_data_i, st_width_i,
        input  st_done_o, st_error_o,
        input  bus_write_o, bus_address_o, bus_data_o, bus_byte_en_o,
        output bus_ready_i, bus_done_i, bus_error_i
    );
endinterface

// File: rtl/store_controller.sv
// Turns one pending store into byte-lane-aligned word writes and reports completion.
// Define MISALIGNED_SPLIT_EN to accept any offset/width, splitting word-crossing stores in two.
module store_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic               clk_i,
    input logic               rst_n_i,
    store_controller_if.slave ctrl_bus
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StNext, StResp} state_e;

    localparam logic [15:0] TimeoutMax = 16'(TIMEOUT_CYCLES);

    state_e      state_q;
    logic [15:0] timeout_cnt_q;
    logic        reject_q;
    logic        st_done_q;
    logic        st_error_q;
    logic        bus_write_q;
    logic [31:0] bus_address_q;
    logic [31:0] bus_data_q;
    logic [3:0]  bus_byte_en_q;

`ifdef MISALIGNED_SPLIT_EN
    logic [29:0] word_addr_q;
    logic [31:0] hi_data_q;
    logic [3:0]  hi_en_q;
    logic        beat1_q;
    logic [7:0]  ext_en;
    logic [63:0] ext_data;
`else
    logic        misaligned;
`endif

    logic [1:0]  off;
    logic [3:0]  mask;
    logic [31:0] data_masked;
    logic [3:0]  lo_en;
    logic [31:0] lo_data;
    logic        bad_req;

    // Lane placement is computed straight from the request so beat 0 is ready at T+1.
    always_comb begin
        off = ctrl_bus.st_address_i[1:0];
        case (ctrl_bus.st_width_i)
            2'b00: begin
                mask        = 4'b0001;
                data_masked = {24'h0, ctrl_bus.st_data_i[7:0]};
            end
            2'b01: begin
                mask        = 4'b0011;
                data_masked = {16'h0, ctrl_bus.st_data_i[15:0]};
            end
            default: begin
                mask        = 4'b1111;
                data_masked = ctrl_bus.st_data_i;
            end
        endcase
`ifdef MISALIGNED_SPLIT_EN
        ext_en   = {4'b0000, mask} << off;
        ext_data = {32'h0, data_masked} << {off, 3'b000};
        lo_en    = ext_en[3:0];
        lo_data  = ext_data[31:0];
        bad_req  = (ctrl_bus.st_width_i == 2'b11);
`else
        misaligned = ((ctrl_bus.st_width_i == 2'b01) && off[0]) ||
                     ((ctrl_bus.st_width_i == 2'b10) && (off != 2'b00));
        // Only naturally aligned stores reach the bus, so nothing spills past lane 3.
        lo_en    = mask << off;
        lo_data  = data_masked << {off, 3'b000};
        bad_req  = (ctrl_bus.st_width_i == 2'b11) || misaligned;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= StIdle;
            timeout_cnt_q <= 16'h0;
            reject_q      <= 1'b0;
            st_done_q     <= 1'b0;
            st_error_q    <= 1'b0;
            bus_write_q   <= 1'b0;
            bus_address_q <= 32'h0;
            bus_data_q    <= 32'h0;
            bus_byte_en_q <= 4'h0;
`ifdef MISALIGNED_SPLIT_EN
            word_addr_q   <= 30'h0;
            hi_data_q     <= 32'h0;
            hi_en_q       <= 4'h0;
            beat1_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ctrl_bus.st_request_i) begin
                        state_q  <= StIssue;
                        reject_q <= bad_req;
                        if (!bad_req) begin
                            bus_write_q   <= 1'b1;
                            bus_address_q <= {ctrl_bus.st_address_i[31:2], 2'b00};
                            bus_data_q    <= lo_data;
                            bus_byte_en_q <= lo_en;
                        end
`ifdef MISALIGNED_SPLIT_EN
                        word_addr_q <= ctrl_bus.st_address_i[31:2];
                        hi_data_q   <= ext_data[63:32];
                        hi_en_q     <= ext_en[7:4];
                        beat1_q     <= 1'b0;
`endif
                    end
                end
                StIssue: begin
                    // A rejected request passes through here only to give done at T+2.
                    if (reject_q) begin
                        st_done_q  <= 1'b1;
                        st_error_q <= 1'b1;
                        state_q    <= StResp;
                    end else if (ctrl_bus.bus_ready_i) begin
                        bus_write_q   <= 1'b0;
                        timeout_cnt_q <= 16'h0;
                        state_q       <= StWait;
                    end
                end
                StWait: begin
                    if (ctrl_bus.bus_done_i) begin
                        if (ctrl_bus.bus_error_i) begin
                            st_done_q  <= 1'b1;
                            st_error_q <= 1'b1;
                            state_q    <= StResp;
`ifdef MISALIGNED_SPLIT_EN
                        end else if (!beat1_q && (hi_en_q != 4'h0)) begin
                            state_q <= StNext;
`endif
                        end else begin
                            st_done_q  <= 1'b1;
                            st_error_q <= 1'b0;
                            state_q    <= StResp;
                        end
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 16'd1;
                        if ((timeout_cnt_q + 16'd1) >= TimeoutMax) begin
                            st_done_q  <= 1'b1;
                            st_error_q <= 1'b1;
                            state_q    <= StResp;
                        end
                    end
                end
                StNext: begin
`ifdef MISALIGNED_SPLIT_EN
                    beat1_q       <= 1'b1;
                    bus_write_q   <= 1'b1;
                    bus_address_q <= {word_addr_q + 30'd1, 2'b00};
                    bus_data_q    <= hi_data_q;
                    bus_byte_en_q <= hi_en_q;
                    state_q       <= StIssue;
`else
                    state_q <= StIdle;
`endif
                end
                StResp: begin
                    st_done_q  <= 1'b0;
                    st_error_q <= 1'b0;
                    reject_q   <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ctrl_bus.st_done_o     = st_done_q;
    assign ctrl_bus.st_error_o    = st_error_q;
    assign ctrl_bus.bus_write_o   = bus_write_q;
    assign ctrl_bus.bus_address_o = bus_address_q;
    assign ctrl_bus.bus_data_o    = bus_data_q;
    assign ctrl_bus.bus_byte_en_o = bus_byte_en_q;

endmodule

// File: doc/store_controller.md
Name: store_controller

Overview:
- Memory-side responder for the store buffer's pull channel.
- Latches one pending store (address, data, width), turns it into byte-lane-aligned word writes on the data memory bus, and waits for bus completion.
- Pulses done so the store buffer can retire the entry and advance its pull pointer.
- Sits between the store buffer and the bus controller; at most one store is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for bus_done_i after a write is accepted before aborting with error (range 1..65535).

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  reset; asynchronous, active-low
- st_request_i  input  1  single-cycle store request from the store buffer
- st_address_i  input  32  byte address of the store
- st_data_i  input  32  store data, right-justified
- st_width_i  input  2  store width: 00 byte, 01 half, 10 word, 11 reserved
- st_done_o  output  1  one-cycle pulse: store finished (success or error)
- st_error_o  output  1  qualifies st_done_o: store failed
- bus_write_o  output  1  write request valid, held until accepted
- bus_address_o  output  32  word-aligned address ([1:0] = 00)
- bus_data_o  output  32  lane-aligned write data
- bus_byte_en_o  output  4  byte enables, bit i = byte lane i
- bus_ready_i  input  1  bus accepts the write when high together with bus_write_o
- bus_done_i  input  1  write completion pulse
- bus_error_i  input  1  qualifies bus_done_i: bus fault

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, NEXT, RESP.
- IDLE:
  - On st_request_i, latch address, data and width; go to ISSUE.
  - st_request_i is ignored in every state except IDLE.
- Lane math:
  - off = addr[1:0].
  - mask = 0001 (byte), 0011 (half), 1111 (word).
  - ext_en = mask << off, 8 bits wide.
  - ext_data = data << 8*off, 64 bits wide.
  - Beat 0: addr {a[31:2],00}, byte_en ext_en[3:0], data ext_data[31:0].
  - Beat 1: addr +4, byte_en ext_en[7:4], data ext_data[63:32].
  - Beat 1 exists iff ext_en[7:4] != 0.
  - For a byte store, bus_data_o must replicate unused lanes as 0.
- ISSUE:
  - bus_write_o = 1 with the current beat's fields; the fields are stable while waiting.
  - When bus_ready_i = 1, clear the timeout counter and go to WAIT. bus_write_o drops the next cycle.
- WAIT:
  - The counter increments each cycle bus_done_i = 0.
  - bus_done_i with bus_error_i → RESP with error.
  - bus_done_i without error:
    - If a second beat is pending, go to NEXT.
    - Otherwise go to RESP with no error.
  - Counter reaching TIMEOUT_CYCLES → RESP with error.
- NEXT: select beat 1; go to ISSUE on the next cycle.
- RESP:
  - st_done_o = 1 and st_error_o = latched error, for exactly one cycle.
  - Return to IDLE.
- Minimum latency:
  - Request at cycle T, bus_write_o at T+1.
  - With bus_ready_i=1 at T+1 and bus_done_i at T+2, st_done_o is at T+3.
- Width 11 (reserved): go directly to RESP with error; no bus activity; st_done_o at T+2.
- Stale bus_done_i in IDLE, ISSUE or NEXT (e.g. after a timeout) is ignored.
- A first-beat error skips beat 1.
- Asynchronous reset mid-operation: bus_write_o drops immediately, the FSM returns to IDLE, and no done pulse is produced.
- Pipelining: a new st_request_i is legal the cycle after st_done_o.

Optional Feature:
- Macro: MISALIGNED_SPLIT_EN.
- Defined: any offset/width is handled. Stores crossing a word boundary issue two beats; half at off=1 is a single beat with byte_en 0110.
- Undefined:
  - Natural alignment is required: half needs a[0]=0; word needs a[1:0]=00.
  - A misaligned store produces no bus activity and goes to RESP with st_error_o=1 (st_done_o at T+2).
  - Beat 1 logic is removed.

Test Plan:
- Byte store, addr 0x1003, data 0x000000AB, bus_ready_i and bus_done_i high immediately → bus_address_o 0x1000, byte_en 1000, bus_data_o 0xAB000000; st_done_o at T+3 with st_error_o=0.
- Word store, addr 0x2000, data 0xDEADBEEF, bus_ready_i held low 5 cycles → bus_write_o and bus_data_o stable for 6 cycles; exactly one done pulse.
- MISALIGNED_SPLIT_EN defined, word store, addr 0x3002, data 0x11223344:
  - Beat 0: addr 0x3000, byte_en 1100, data 0x33440000.
  - Beat 1: addr 0x3004, byte_en 0011, data 0x00001122.
  - Single done pulse.
- MISALIGNED_SPLIT_EN undefined, same stimulus → bus_write_o never asserted; st_done_o and st_error_o=1 at T+2.
- TIMEOUT_CYCLES=4, bus accepts but bus_done_i never arrives → done+error 4 cycles after acceptance. A later bus_done_i is ignored, and the next request completes normally.
- Drop rst_n_i while in ISSUE → bus_write_o=0 immediately; no st_done_o; the next request after reset behaves as in scenario 1.
